// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO interconnect: FSM state type, default
// timeout read data and the conventional peripheral slot numbers.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  localparam int unsigned SLV_MEM   = 0;
  localparam int unsigned SLV_TIMER = 1;
  localparam int unsigned SLV_UART  = 2;
  localparam int unsigned SLV_GPIO  = 3;

endpackage

// File: rtl/mmio_bus_fabric_if.sv
// CPU data-port bundle between the MIPS core (master) and the fabric (slave).
interface mmio_bus_fabric_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic [AW-1:0] cpu_addr;
  logic          cpu_re;
  logic          cpu_we;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  modport master (
    output cpu_addr, cpu_re, cpu_we, cpu_wdata,
    input  cpu_rdata, cpu_stall
  );

  modport slave (
    input  cpu_addr, cpu_re, cpu_we, cpu_wdata,
    output cpu_rdata, cpu_stall
  );

endinterface

// File: rtl/mmio_addr_match.sv
// Priority base/mask decoder: lowest-numbered matching slot wins; hit=0 when
// no entry matches so the caller can apply its own fallback slot.
module mmio_addr_match #(
  parameter int unsigned           N_SLV    = 4,
  parameter int unsigned           AW       = 32,
  parameter int unsigned           SEL_W    = 2,
  parameter logic [N_SLV*AW-1:0]   BASE_TBL = '0,
  parameter logic [N_SLV*AW-1:0]   MASK_TBL = '0
) (
  input  logic [AW-1:0]    addr,
  output logic [SEL_W-1:0] sel,
  output logic             hit
);

  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      if (!hit && ((addr & MASK_TBL[i*AW +: AW]) == BASE_TBL[i*AW +: AW])) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mmio_bus_fabric.sv
// Memory-mapped interconnect from the core data port to N_SLV peripherals:
// address decode, one-cold chip select, stall until ready, timeout with sticky error.
module mmio_bus_fabric
  import mmio_pkg::*;
#(
  parameter int unsigned         N_SLV    = 4,
  parameter int unsigned         DW       = 32,
  parameter int unsigned         AW       = 32,
  parameter int unsigned         SLV_AW   = 12,
  parameter logic [N_SLV*AW-1:0] BASE_TBL = {32'hFFFF_2000, 32'hFFFF_1000,
                                             32'hFFFF_0000, 32'h0000_0000},
  parameter logic [N_SLV*AW-1:0] MASK_TBL = {32'hFFFF_F000, 32'hFFFF_F000,
                                             32'hFFFF_F000, 32'hF000_0000},
  parameter int unsigned         DEF_SLV  = SLV_MEM,
  parameter int unsigned         TIMEOUT  = 15,
  parameter logic [DW-1:0]       ERR_DATA = DW'(DEF_ERR_DATA)
) (
  input  logic                  clk,
  input  logic                  reset,
  mmio_bus_fabric_if.slave      cpu,
  output logic [N_SLV-1:0]      slv_cs_n,
  output logic                  slv_rd_n,
  output logic                  slv_wr_n,
  output logic [SLV_AW-1:0]     slv_addr,
  output logic [DW-1:0]         slv_wdata,
  input  logic [N_SLV*DW-1:0]   slv_rdata,
  input  logic [N_SLV-1:0]      slv_ready,
  input  logic                  err_clr,
  output logic                  bus_err,
  output logic [AW-1:0]         err_addr
);

  localparam int unsigned SEL_W    = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                bus_err_q, bus_err_d;
  logic [AW-1:0]       err_addr_q, err_addr_d;

  logic [SEL_W-1:0]    match_sel;
  logic                match_hit;
  logic [SEL_W-1:0]    dec_sel;
  logic                req;
  logic                ready_sel;
  logic [DW-1:0]       rdata_sel;
  logic                err_set;

  mmio_addr_match #(
    .N_SLV   (N_SLV),
    .AW      (AW),
    .SEL_W   (SEL_W),
    .BASE_TBL(BASE_TBL),
    .MASK_TBL(MASK_TBL)
  ) u_match (
    .addr(cpu.cpu_addr),
    .sel (match_sel),
    .hit (match_hit)
  );

  assign dec_sel   = match_hit ? match_sel : SEL_W'(DEF_SLV);
  assign req       = cpu.cpu_re | cpu.cpu_we;
  assign ready_sel = slv_ready[sel_q];
  assign rdata_sel = slv_rdata[DW*32'(sel_q) +: DW];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    sel_d      = sel_q;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    err_set    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = cpu.cpu_addr;
          wdata_d = cpu.cpu_wdata;
          we_d    = cpu.cpu_we;
          sel_d   = dec_sel;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        // Ready is checked first so a ready on the final allowed cycle is not an error.
        if (ready_sel) begin
          if (!we_q) rdata_d = rdata_sel;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          if (!we_q) rdata_d = ERR_DATA;
          err_set    = 1'b1;
          err_addr_d = addr_q;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    bus_err_d = bus_err_q;
    if (err_clr) bus_err_d = 1'b0;
    if (err_set) bus_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      rdata_q    <= rdata_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    slv_cs_n = '1;
    if (state_q == ST_ACCESS) slv_cs_n[sel_q] = 1'b0;
  end

  assign slv_rd_n      = !((state_q == ST_ACCESS) && !we_q);
  assign slv_wr_n      = !((state_q == ST_ACCESS) && we_q);
  assign slv_addr      = addr_q[SLV_AW-1:0];
  assign slv_wdata     = wdata_q;
  assign cpu.cpu_stall = ((state_q == ST_IDLE) && req) || (state_q == ST_ACCESS);
  assign cpu.cpu_rdata = rdata_q;
  assign bus_err       = bus_err_q;
  assign err_addr      = err_addr_q;

endmodule
